// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions.
// Provides: word_t, opcode_t, regbits_t, the HALT opcode constant,
// pcsrc_t (next-PC source select, shared with control_unit) and
// fetch_state_t (fetch stage state encoding).
package cpu_types_pkg;

  localparam int WORD_W   = 32;
  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;

  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [OPCODE_W-1:0] opcode_t;
  typedef logic [REG_W-1:0]    regbits_t;

  localparam opcode_t HALT = 6'b111111;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_JR  = 2'b01,
    PC_BR  = 2'b10,
    PC_JMP = 2'b11
  } pcsrc_t;

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } fetch_state_t;

  // Sign-extended, word-scaled branch offset.
  function automatic word_t branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit signal bundle.
// Ports: CLK (input). Carries the instruction-memory request/response,
// the decode-side output buffer handshake, the redirect resolution inputs
// and the halted status.
// Modports: fu (the fetch block), tb (the bench driving it).
interface fetch_unit_if (
  input logic CLK
);
  import cpu_types_pkg::*;

  logic        nRST;
  logic        ihit;
  word_t       iload;
  logic        iREN;
  word_t       iaddr;
  logic        id_valid;
  logic        id_ready;
  word_t       id_instr;
  word_t       id_npc;
  logic        res_en;
  logic [1:0]  res_pcsrc;
  logic        res_branch;
  logic        res_zero;
  word_t       res_npc;
  logic [15:0] res_imm;
  logic [25:0] res_jaddr;
  word_t       res_rsdata;
  logic        halted;

  modport fu (
    input  CLK, nRST, ihit, iload, id_ready,
    input  res_en, res_pcsrc, res_branch, res_zero, res_npc,
    input  res_imm, res_jaddr, res_rsdata,
    output iREN, iaddr, id_valid, id_instr, id_npc, halted
  );

  modport tb (
    input  CLK, iREN, iaddr, id_valid, id_instr, id_npc, halted,
    output nRST, ihit, iload, id_ready,
    output res_en, res_pcsrc, res_branch, res_zero, res_npc,
    output res_imm, res_jaddr, res_rsdata
  );

endinterface

// File: rtl/npc_calc.sv
// Redirect resolution: decides whether the resolving instruction takes a
// control transfer and computes its target. Purely combinational.
// Ports:
//   en      - resolving instruction present
//   pcsrc   - next-PC source (seq / JR / branch / J,JAL)
//   branch  - 1 = BEQ sense, 0 = BNE sense
//   zero    - ALU zero flag
//   npc     - PC+4 of the resolving instruction
//   imm     - branch offset field
//   jaddr   - jump index field
//   rsdata  - rs value for JR
//   taken   - redirect taken
//   target  - redirect target address
module npc_calc
  import cpu_types_pkg::*;
(
  input  logic        en,
  input  pcsrc_t      pcsrc,
  input  logic        branch,
  input  logic        zero,
  input  word_t       npc,
  input  logic [15:0] imm,
  input  logic [25:0] jaddr,
  input  word_t       rsdata,
  output logic        taken,
  output word_t       target
);

  always_comb begin
    taken  = 1'b0;
    target = npc;
    case (pcsrc)
      PC_JR: begin
        taken  = en;
        // JR targets are passed through unaligned on purpose.
        target = rsdata;
      end
      PC_BR: begin
        // BEQ takes on zero, BNE takes on non-zero: taken when sense matches flag.
        taken  = en && (branch == zero);
        target = npc + branch_offset(imm);
      end
      PC_JMP: begin
        taken  = en;
        target = {npc[31:28], jaddr, 2'b00};
      end
      default: begin
        taken  = 1'b0;
        target = npc;
      end
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage.
// Owns the PC, drives the instruction-memory request and holds one fetched
// instruction (with its PC+4) for decode. Applies redirects resolved
// downstream and stops fetching once a HALT has been handed to decode.
// Ports:
//   CLK, nRST                 - clock, async active-low reset
//   ihit, iload               - instruction memory response
//   iREN, iaddr               - instruction memory request (iaddr = pc)
//   id_valid, id_ready        - output buffer handshake with decode
//   id_instr, id_npc          - buffered instruction and its PC+4
//   res_*                     - redirect resolution from decode/execute
//   halted                    - HALT consumed, fetch stopped
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_npc,
  input  logic        res_en,
  input  logic [1:0]  res_pcsrc,
  input  logic        res_branch,
  input  logic        res_zero,
  input  logic [31:0] res_npc,
  input  logic [15:0] res_imm,
  input  logic [25:0] res_jaddr,
  input  logic [31:0] res_rsdata,
  output logic        halted
);

  fetch_state_t state_reg;
  word_t        pc_reg;
  logic         id_valid_reg;
  word_t        id_instr_reg;
  word_t        id_npc_reg;
  logic         halted_reg;

  logic         redirect_taken;
  word_t        redirect_target;
  word_t        pc_plus4;

  npc_calc u_npc_calc (
    .en     (res_en),
    .pcsrc  (pcsrc_t'(res_pcsrc)),
    .branch (res_branch),
    .zero   (res_zero),
    .npc    (res_npc),
    .imm    (res_imm),
    .jaddr  (res_jaddr),
    .rsdata (res_rsdata),
    .taken  (redirect_taken),
    .target (redirect_target)
  );

  assign pc_plus4 = pc_reg + 32'd4;

  // Request only when there is room in the buffer (or it drains this cycle).
  assign iREN     = (state_reg == FETCH) && (!id_valid_reg || id_ready);
  assign iaddr    = pc_reg;
  assign id_valid = id_valid_reg;
  assign id_instr = id_instr_reg;
  assign id_npc   = id_npc_reg;
  assign halted   = halted_reg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg    <= FETCH;
      pc_reg       <= PC_INIT;
      id_valid_reg <= 1'b0;
      id_instr_reg <= '0;
      id_npc_reg   <= '0;
      halted_reg   <= 1'b0;
    end else begin
      case (state_reg)
        HALTED: begin
          // Terminal: everything holds until reset.
        end
        default: begin
          if (redirect_taken) begin
            // Redirect wins over any coincident fetch and cancels a
            // wrong-path HALT waiting in the buffer.
            pc_reg       <= redirect_target;
            id_valid_reg <= 1'b0;
            state_reg    <= FETCH;
          end else if (iREN && ihit) begin
            id_instr_reg <= iload;
            id_npc_reg   <= pc_plus4;
            id_valid_reg <= 1'b1;
            pc_reg       <= pc_plus4;
            if (opcode_t'(iload[31:26]) == HALT) begin
              state_reg <= DRAIN;
            end
          end else if (id_ready && id_valid_reg) begin
            id_valid_reg <= 1'b0;
            if (state_reg == DRAIN) begin
              state_reg  <= HALTED;
              halted_reg <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall, branch/jump
// redirects, HALT drain, HALT cancelled by a jump, and async reset.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if fif (.CLK(clk));

  // Instruction memory model: returns a marker word derived from the
  // address, or HALT at halt_addr.
  word_t halt_addr;
  assign fif.iload = (fif.iaddr == halt_addr) ? 32'hFC00_0000 : (32'h2000_0000 | fif.iaddr);

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK        (clk),
    .nRST       (fif.nRST),
    .ihit       (fif.ihit),
    .iload      (fif.iload),
    .iREN       (fif.iREN),
    .iaddr      (fif.iaddr),
    .id_valid   (fif.id_valid),
    .id_ready   (fif.id_ready),
    .id_instr   (fif.id_instr),
    .id_npc     (fif.id_npc),
    .res_en     (fif.res_en),
    .res_pcsrc  (fif.res_pcsrc),
    .res_branch (fif.res_branch),
    .res_zero   (fif.res_zero),
    .res_npc    (fif.res_npc),
    .res_imm    (fif.res_imm),
    .res_jaddr  (fif.res_jaddr),
    .res_rsdata (fif.res_rsdata),
    .halted     (fif.halted)
  );

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
    $display("cyc %0d: iREN=%0b iaddr=0x%08h id_valid=%0b id_instr=0x%08h id_npc=0x%08h halted=%0b",
             cycle, fif.iREN, fif.iaddr, fif.id_valid, fif.id_instr, fif.id_npc, fif.halted);
  endtask

  task automatic resolve(input logic [1:0] pcsrc, input logic br, input logic z,
                         input word_t npc, input logic [15:0] imm,
                         input logic [25:0] jaddr, input word_t rs);
    fif.res_en     = 1'b1;
    fif.res_pcsrc  = pcsrc;
    fif.res_branch = br;
    fif.res_zero   = z;
    fif.res_npc    = npc;
    fif.res_imm    = imm;
    fif.res_jaddr  = jaddr;
    fif.res_rsdata = rs;
  endtask

  initial begin
    halt_addr      = 32'hFFFF_FFF0;
    fif.nRST       = 1'b0;
    fif.ihit       = 1'b0;
    fif.id_ready   = 1'b0;
    fif.res_en     = 1'b0;
    fif.res_pcsrc  = 2'b00;
    fif.res_branch = 1'b0;
    fif.res_zero   = 1'b0;
    fif.res_npc    = '0;
    fif.res_imm    = '0;
    fif.res_jaddr  = '0;
    fif.res_rsdata = '0;

    // Reset state
    #12;
    check_eq("rst_iaddr", fif.iaddr, 32'h0);
    check_eq("rst_valid", {31'b0, fif.id_valid}, 32'h0);
    check_eq("rst_instr", fif.id_instr, 32'h0);
    check_eq("rst_npc", fif.id_npc, 32'h0);
    check_eq("rst_halted", {31'b0, fif.halted}, 32'h0);
    check_eq("rst_iren", {31'b0, fif.iREN}, 32'h1);

    @(negedge clk);
    fif.nRST     = 1'b1;
    fif.ihit     = 1'b1;
    fif.id_ready = 1'b1;

    // Sequential fetch, one per cycle
    for (int i = 1; i <= 3; i++) begin
      step();
      check_eq("seq_iaddr", fif.iaddr, 32'(4 * i));
      check_eq("seq_npc", fif.id_npc, 32'(4 * i));
      check_eq("seq_instr", fif.id_instr, 32'h2000_0000 | 32'(4 * (i - 1)));
      check_eq("seq_valid", {31'b0, fif.id_valid}, 32'h1);
    end

    // Stall with full buffer
    fif.id_ready = 1'b0;
    #1;
    check_eq("stall_iren", {31'b0, fif.iREN}, 32'h0);
    step();
    step();
    check_eq("stall_iaddr", fif.iaddr, 32'hC);
    check_eq("stall_instr", fif.id_instr, 32'h2000_0008);
    fif.id_ready = 1'b1;
    step();
    check_eq("resume_instr", fif.id_instr, 32'h2000_000C);
    check_eq("resume_iaddr", fif.iaddr, 32'h10);
    check_eq("resume_valid", {31'b0, fif.id_valid}, 32'h1);

    // BEQ taken: 0x100 + (-2<<2) = 0xF8, buffer squashed
    resolve(2'b10, 1'b1, 1'b1, 32'h100, 16'hFFFE, 26'h0, 32'h0);
    step();
    check_eq("beq_iaddr", fif.iaddr, 32'hF8);
    check_eq("beq_squash", {31'b0, fif.id_valid}, 32'h0);
    fif.res_en = 1'b0;
    step();
    check_eq("beq_fetch_npc", fif.id_npc, 32'hFC);
    // BEQ not taken: sequential fetch continues
    resolve(2'b10, 1'b1, 1'b0, 32'h100, 16'hFFFE, 26'h0, 32'h0);
    step();
    check_eq("beq_nt_iaddr", fif.iaddr, 32'h100);
    check_eq("beq_nt_instr", fif.id_instr, 32'h2000_00FC);
    check_eq("beq_nt_valid", {31'b0, fif.id_valid}, 32'h1);

    // BNE taken: 0x40 + 12 = 0x4C
    resolve(2'b10, 1'b0, 1'b0, 32'h40, 16'h0003, 26'h0, 32'h0);
    step();
    check_eq("bne_iaddr", fif.iaddr, 32'h4C);
    // J: {0xA, 0x40, 00} = 0xA000_0100
    resolve(2'b11, 1'b0, 1'b0, 32'hA000_0010, 16'h0, 26'h000_0040, 32'h0);
    step();
    check_eq("j_iaddr", fif.iaddr, 32'hA000_0100);
    // JR
    resolve(2'b01, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h1234);
    step();
    check_eq("jr_iaddr", fif.iaddr, 32'h1234);
    fif.res_en = 1'b0;

    // HALT fetched, held in buffer, then consumed
    halt_addr    = 32'h1234;
    fif.id_ready = 1'b0;
    step();
    check_eq("halt_instr", fif.id_instr, 32'hFC00_0000);
    check_eq("drain_iren", {31'b0, fif.iREN}, 32'h0);
    check_eq("drain_valid", {31'b0, fif.id_valid}, 32'h1);
    step();
    check_eq("drain_hold_iaddr", fif.iaddr, 32'h1238);
    check_eq("drain_halted", {31'b0, fif.halted}, 32'h0);
    fif.id_ready = 1'b1;
    step();
    check_eq("halted", {31'b0, fif.halted}, 32'h1);
    check_eq("halted_valid", {31'b0, fif.id_valid}, 32'h0);
    check_eq("halted_iren", {31'b0, fif.iREN}, 32'h0);
    resolve(2'b11, 1'b0, 1'b0, 32'h0, 16'h0, 26'h100, 32'h0);
    step();
    check_eq("halted_ign_iaddr", fif.iaddr, 32'h1238);
    check_eq("halted_ign_halted", {31'b0, fif.halted}, 32'h1);
    fif.res_en = 1'b0;

    // Reset out of HALTED; then HALT cancelled by a jump coinciding with id_ready
    fif.nRST = 1'b0;
    #1;
    check_eq("rst2_halted", {31'b0, fif.halted}, 32'h0);
    check_eq("rst2_iaddr", fif.iaddr, 32'h0);
    halt_addr = 32'h0;
    @(negedge clk);
    fif.nRST = 1'b1;
    step();
    check_eq("halt2_instr", fif.id_instr, 32'hFC00_0000);
    check_eq("halt2_iren", {31'b0, fif.iREN}, 32'h0);
    resolve(2'b11, 1'b0, 1'b0, 32'h0000_0010, 16'h0, 26'h20, 32'h0);
    step();
    check_eq("cancel_iaddr", fif.iaddr, 32'h80);
    check_eq("cancel_halted", {31'b0, fif.halted}, 32'h0);
    check_eq("cancel_valid", {31'b0, fif.id_valid}, 32'h0);
    check_eq("cancel_iren", {31'b0, fif.iREN}, 32'h1);
    fif.res_en = 1'b0;
    step();
    check_eq("cancel_fetch_npc", fif.id_npc, 32'h84);
    check_eq("cancel_fetch_iaddr", fif.iaddr, 32'h84);

    // Async reset mid-fetch, away from any clock edge
    #2;
    fif.nRST = 1'b0;
    #1;
    check_eq("async_iaddr", fif.iaddr, 32'h0);
    check_eq("async_valid", {31'b0, fif.id_valid}, 32'h0);
    check_eq("async_npc", fif.id_npc, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
